// File: rtl/pong_pkg.sv
// Shared definitions for the Pong LCD scan path.
// Panel geometry defaults, address widths and the scan FSM encoding.
package pong_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 9;

    localparam logic [X_W-1:0] X_MAX_DEF = 8'd239;
    localparam logic [Y_W-1:0] Y_MAX_DEF = 9'd320;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        SCAN,
        ADVANCE,
        DONE
    } scan_state_t;

endpackage

// File: rtl/scan_x_counter.sv
// Column counter for the frame scan: clears in idle, steps on each
// accepted pixel and flags the last column so the FSM can change rows.
module scan_x_counter
    import pong_pkg::*;
#(
    parameter logic [X_W-1:0] X_MAX = X_MAX_DEF
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clear,
    input  logic           step,
    output logic [X_W-1:0] x_addr,
    output logic           last
);

    assign last = (x_addr == X_MAX);

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            x_addr <= '0;
        end else if (step) begin
            x_addr <= last ? '0 : x_addr + 1'b1;
        end
    end

endmodule

// File: rtl/frame_scan_ctrl.sv
// Raster scan sequencer: walks every pixel of the panel on request,
// stepping the external row counter and handshaking with the writer.
module frame_scan_ctrl
    import pong_pkg::*;
#(
    parameter logic [X_W-1:0] X_MAX = X_MAX_DEF,
    parameter logic [Y_W-1:0] Y_MAX = Y_MAX_DEF
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           frame_start,
    input  logic [Y_W-1:0] y_addr,
    output logic           y_enable,
    output logic [X_W-1:0] x_addr,
    output logic           pixel_valid,
    input  logic           pixel_ready,
    output logic           busy,
    output logic           frame_done
);

    scan_state_t state;
    scan_state_t state_next;
    logic        x_step;
    logic        x_last;
    logic        x_clear;

    assign x_clear = (state == IDLE);

    scan_x_counter #(
        .X_MAX(X_MAX)
    ) u_x_counter (
        .clock (clock),
        .reset (reset),
        .clear (x_clear),
        .step  (x_step),
        .x_addr(x_addr),
        .last  (x_last)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        y_enable    = 1'b0;
        pixel_valid = 1'b0;
        busy        = (state != IDLE);
        frame_done  = 1'b0;
        x_step      = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    state_next = (y_addr == '0) ? SCAN : ALIGN;
                end
            end
            ALIGN: begin
                // Row counter may have been left mid-frame; spin it to 0
                y_enable = (y_addr != '0);
                if (y_addr == '0) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                pixel_valid = 1'b1;
                if (pixel_ready) begin
                    x_step = 1'b1;
                    if (x_last) begin
                        state_next = ADVANCE;
                    end
                end
            end
            ADVANCE: begin
                y_enable   = 1'b1;
                state_next = (y_addr == Y_MAX) ? DONE : SCAN;
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Bench for frame_scan_ctrl on a small 4x3 panel with a modelled
// row counter, cycle tables and a raster-order pixel scoreboard.
module tb_frame_scan_ctrl;

    localparam logic [7:0] XM = 8'd3;
    localparam logic [8:0] YM = 9'd2;

    logic       clock;
    logic       reset;
    logic       frame_start;
    logic [8:0] y_addr;
    logic       y_enable;
    logic [7:0] x_addr;
    logic       pixel_valid;
    logic       pixel_ready;
    logic       busy;
    logic       frame_done;

    frame_scan_ctrl #(
        .X_MAX(XM),
        .Y_MAX(YM)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .frame_start(frame_start),
        .y_addr     (y_addr),
        .y_enable   (y_enable),
        .x_addr     (x_addr),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // row counter model
    logic       rc_load;
    logic [8:0] rc_val;
    always @(posedge clock) begin
        if (rc_load)
            y_addr <= rc_val;
        else if (y_enable)
            y_addr <= (y_addr == YM) ? 9'd0 : y_addr + 9'd1;
    end

    // raster-order reference
    typedef struct packed {
        logic [7:0] x;
        logic [8:0] y;
    } pix_t;
    pix_t exp_q[$];

    task automatic load_frame();
        exp_q.delete();
        for (int yy = 0; yy <= int'(YM); yy++)
            for (int xx = 0; xx <= int'(XM); xx++)
                exp_q.push_back('{x: 8'(xx), y: 9'(yy)});
    endtask

    // monitor
    bit   sb_on = 0;
    int   n_acc = 0;
    int   n_ye = 0;
    int   n_done = 0;
    bit   prev_stall = 0;
    pix_t prev_pix;
    pix_t got;

    always @(negedge clock) begin
        if (prev_stall)
            chk("hold", 32'({pixel_valid, x_addr, y_addr}),
                32'({1'b1, prev_pix}));
        if (pixel_valid && pixel_ready && reset) begin
            n_acc++;
            if (sb_on) begin
                got = '{x: x_addr, y: y_addr};
                if (exp_q.size() == 0)
                    chk("sb_extra", 32'(got), 32'h1ffff);
                else
                    chk("sb_pixel", 32'(got), 32'(exp_q.pop_front()));
            end
        end
        if (y_enable) n_ye++;
        if (frame_done) n_done++;
        prev_stall = pixel_valid && !pixel_ready && reset;
        prev_pix   = '{x: x_addr, y: y_addr};
    end

    // random drivers
    bit rand_ready = 0;
    bit rand_start = 0;
    int duty = 100;
    always begin
        @(posedge clock);
        #1;
        if (rand_ready)
            pixel_ready = ($urandom_range(0, 99) < duty);
        if (rand_start)
            frame_start = busy && ($urandom_range(0, 7) == 0);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_frame(input int bound, output bit ok,
                             output int scan_cyc, output int ye_pre);
        int c;
        int first;
        c = 0;
        first = -1;
        ok = 0;
        scan_cyc = 0;
        ye_pre = 0;
        while (c < bound) begin
            @(negedge clock);
            c++;
            if (pixel_valid && first < 0) first = c;
            if (first < 0 && y_enable) ye_pre++;
            if (frame_done) begin
                ok = 1;
                scan_cyc = c - first + 1;
                break;
            end
        end
    endtask

    task automatic clr_counts();
        n_acc = 0;
        n_ye = 0;
        n_done = 0;
    endtask

    typedef struct {
        logic       start;
        logic       ready;
        logic       valid;
        logic [7:0] x;
        logic [8:0] y;
        logic       ye;
        logic       bsy;
        logic       done;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic s, input logic r, input logic v,
                       input int x, input int y, input logic ye,
                       input logic b, input logic d);
        tbl.push_back('{s, r, v, 8'(x), 9'(y), ye, b, d});
    endtask

    bit ok;
    int scyc;
    int yep;
    int dutys[4] = '{20, 50, 80, 100};

    initial begin
        reset = 1'b0;
        frame_start = 1'b0;
        pixel_ready = 1'b0;
        rc_load = 1'b1;
        rc_val = 9'd0;

        // cycle table: idle, scan with stalls, advances, done, idle
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1, 0);
        add(0, 0, 1, 1, 0, 0, 1, 0);
        add(1, 1, 1, 1, 0, 0, 1, 0);
        add(0, 1, 1, 2, 0, 0, 1, 0);
        add(0, 1, 1, 3, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 1, i, 1, 0, 1, 0);
        add(0, 1, 0, 0, 1, 1, 1, 0);
        add(0, 0, 1, 0, 2, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 1, i, 2, 0, 1, 0);
        add(0, 1, 0, 0, 2, 1, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);

        repeat (3) tick();
        rc_load = 1'b0;
        @(negedge clock);
        chk("reset_out",
            32'({x_addr, pixel_valid, busy, frame_done, y_enable}), 32'd0);
        tick();
        reset = 1'b1;

        foreach (tbl[i]) begin
            frame_start = tbl[i].start;
            pixel_ready = tbl[i].ready;
            @(negedge clock);
            chk($sformatf("tbl%0d", i),
                32'({pixel_valid, x_addr, y_addr, y_enable, busy,
                     frame_done}),
                32'({tbl[i].valid, tbl[i].x, tbl[i].y, tbl[i].ye,
                     tbl[i].bsy, tbl[i].done}));
            tick();
        end
        frame_start = 1'b0;

        // frame length and counts with ready held high
        clr_counts();
        pixel_ready = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        run_frame(100, ok, scyc, yep);
        chk("len_done", 32'(ok), 32'd1);
        chk("len_cycles", 32'(scyc), 32'(16));
        chk("len_pixels", 32'(n_acc), 32'd12);
        chk("len_yen", 32'(n_ye), 32'd3);
        tick();
        chk("len_yend", 32'(y_addr), 32'd0);

        // random ready duty, random start re-pulses
        rand_ready = 1;
        for (int f = 0; f < 4; f++) begin
            duty = dutys[f];
            load_frame();
            clr_counts();
            sb_on = 1;
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            rand_start = 1;
            run_frame(400, ok, scyc, yep);
            rand_start = 0;
            frame_start = 1'b0;
            chk("rnd_done", 32'(ok), 32'd1);
            repeat (4) tick();
            chk("rnd_ndone", 32'(n_done), 32'd1);
            chk("rnd_left", 32'(exp_q.size()), 32'd0);
            chk("rnd_idle", 32'(busy), 32'd0);
            sb_on = 0;
        end
        rand_ready = 0;
        pixel_ready = 1'b1;

        // row counter preset away from 0
        rc_load = 1'b1;
        rc_val = 9'd1;
        tick();
        rc_load = 1'b0;
        load_frame();
        clr_counts();
        sb_on = 1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        run_frame(100, ok, scyc, yep);
        chk("aln_done", 32'(ok), 32'd1);
        chk("aln_pulses", 32'(yep), 32'd2);
        tick();
        chk("aln_left", 32'(exp_q.size()), 32'd0);
        sb_on = 0;

        // reset in the middle of a frame
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clock);
            if (pixel_valid && x_addr == 8'd2 && y_addr == 9'd1) ok = 1;
        end
        chk("mid_found", 32'(ok), 32'd1);
        reset = 1'b0;
        tick();
        chk("mid_rst",
            32'({x_addr, pixel_valid, busy, frame_done, y_enable}), 32'd0);
        chk("mid_ykeep", 32'(y_addr), 32'd1);
        reset = 1'b1;
        tick();
        load_frame();
        clr_counts();
        sb_on = 1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        run_frame(100, ok, scyc, yep);
        chk("rec_done", 32'(ok), 32'd1);
        chk("rec_align", 32'(yep), 32'd2);
        tick();
        chk("rec_left", 32'(exp_q.size()), 32'd0);
        chk("rec_ndone", 32'(n_done), 32'd1);
        sb_on = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/frame_scan_ctrl.md
# frame_scan_ctrl

Frame scan sequencer for the Pong LCD path. On a frame request it walks every pixel of the panel in raster order: it owns the column address and drives the row counter's `enable`, consuming that counter's `y_addr` output. It presents each pixel position to the downstream LCD pixel writer through a valid/ready handshake and pulses `frame_done` when the last pixel has been accepted.

## Interface
- `X_MAX`, default 8'd239: last column index; columns run 0..X_MAX.
- `Y_MAX`, default 9'd320: last row index; must equal the row counter's `Y_MAX`.

- `clock` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-low. The block resets on a rising `clock` edge while `reset`==0.
- `frame_start` in 1: single-cycle request to scan one frame.
- `y_addr` in 9: current row from the row counter.
- `y_enable` out 1: advances the row counter by one, wrapping Y_MAX→0.
- `x_addr` out 8: current column.
- `pixel_valid` out 1: (`x_addr`, `y_addr`) is a pixel to be written.
- `pixel_ready` in 1: the LCD writer accepts the pixel this cycle.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse after the last pixel is accepted.

## Operation
- States: IDLE, ALIGN, SCAN, ADVANCE, DONE.
- Reset: state IDLE, `x_addr`=0, and `y_enable`, `pixel_valid`, `busy`, `frame_done` all 0. `y_addr` is not touched, because the row counter has its own reset.
- IDLE:
  - `frame_start`=1 and `y_addr`==0 → SCAN.
  - `frame_start`=1 and `y_addr`!=0 → ALIGN.
  - `frame_start` is ignored in all other states; no request is queued.
- ALIGN: `y_enable` = (`y_addr`!=0), so the row counter steps once per cycle until it wraps. `y_addr`==0 → SCAN. This recovers a row counter left mid-frame by a reset.
- SCAN: `pixel_valid`=1.
  - On `pixel_valid`&&`pixel_ready`: if `x_addr`==X_MAX, set `x_addr`←0 and go to ADVANCE; otherwise `x_addr`←`x_addr`+1.
  - While `pixel_ready`=0, `x_addr`, `y_addr` and `pixel_valid` hold stable.
- ADVANCE: `y_enable`=1 for exactly one cycle and `pixel_valid`=0.
  - If `y_addr`==Y_MAX (the value before the increment) → DONE, and the row counter wraps to 0.
  - Otherwise → SCAN.
- DONE: `frame_done`=1 for one cycle, then → IDLE.
- Arithmetic: `x_addr` is 8-bit unsigned and never exceeds X_MAX. Comparisons are equality only.

## Timing
- `frame_start` at cycle t, with `y_addr`==0: `pixel_valid`=1 at t+1 with (0,0).
- Each ALIGN cycle advances `y_addr` by one. SCAN is entered on the cycle after `y_addr` reads 0.
- With `pixel_ready` held at 1, one pixel is accepted per cycle. Each row costs X_MAX+1 SCAN cycles plus 1 ADVANCE cycle.
- Frame duration from entering SCAN to `frame_done` is (X_MAX+2)·(Y_MAX+1) cycles, plus 1 for DONE.
- After ADVANCE, the next SCAN cycle already sees the incremented `y_addr`.
- `y_enable` is never high in IDLE, SCAN or DONE.
- Reset asserted mid-frame: the next cycle is IDLE with all outputs 0, and any pending pixel is dropped.

## Structure
- Shared package `pong_pkg`:
  - state enum `scan_state_t`;
  - default X_MAX/Y_MAX constants;
  - X/Y address widths (8/9).
  The row counter's default is taken from the same package.
- One natural sub-module: `scan_x_counter`, the column counter with clear, increment-on-accept and wrap flag. The FSM stays in `frame_scan_ctrl`.
- Integration: `y_enable` connects to the row counter's `enable`, and that counter's `y_addr` returns to this block.

## Test plan
- Reset, then `frame_start` with `pixel_ready`=1 and `y_addr`=0 → pixels emitted (0,0)…(239,0),(0,1)…(239,320). `frame_done` arrives 241·321+1 cycles after SCAN entry, and `y_addr` ends at 0.
- `pixel_ready` toggling with a random duty cycle → no pixel is skipped or duplicated, and `x_addr`/`y_addr` are stable while `pixel_valid`&&!`pixel_ready`.
- Row counter preset to 5 before `frame_start` → ALIGN pulses `y_enable` for 316 cycles, and the first pixel is (0,0).
- `frame_start` re-pulsed mid-frame → ignored; exactly one `frame_done` is produced.
- `reset`=0 at pixel (100,50) → next cycle IDLE with `x_addr`=0 and all outputs 0. A later `frame_start` aligns and completes a full frame.
- Small parameters X_MAX=3, Y_MAX=2 → exactly 12 accepted pixels, 3 `y_enable` pulses, and `frame_done` on the 16th cycle after SCAN entry.
